// File: rtl/game_turn_controller.sv
// Two-player turn/scoring controller: tracks whose turn it is, hit counts and
// the per-turn timer, and emits a status code plus a one-cycle write strobe.
module game_turn_controller #(
  parameter int HITS_TO_WIN = 5,
  parameter int TURN_TICKS  = 30,
  parameter int ERR_TICKS   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       restart,
  input  logic       move_valid,
  input  logic       move_ok,
  input  logic       hit,
  output logic       write_en,
  output logic [7:0] new_state,
  output logic       turn,
  output logic [3:0] p1_hits,
  output logic [3:0] p2_hits,
  output logic [5:0] time_left,
  output logic       game_over
);

  typedef enum logic [1:0] {
    ST_TURN_P1,
    ST_TURN_P2,
    ST_ERROR,
    ST_GAME_OVER
  } state_t;

  localparam logic [3:0] WIN_COUNT  = 4'(HITS_TO_WIN);
  localparam logic [5:0] TURN_LOAD  = 6'(TURN_TICKS);
  localparam logic [3:0] ERR_LAST   = 4'(ERR_TICKS - 1);

  state_t     state, state_nxt;
  logic [3:0] err_cnt, err_nxt;
  logic       turn_nxt;
  logic [3:0] p1_nxt, p2_nxt;
  logic [5:0] time_nxt;
  logic [7:0] code_nxt;
  logic       we_nxt;
  logic       over_nxt;
  logic [3:0] mover_hits, mover_inc;

  assign mover_hits = turn ? p2_hits : p1_hits;
  // Saturate rather than wrap, even though a legal HITS_TO_WIN never gets here.
  assign mover_inc  = (mover_hits == 4'hF) ? 4'hF : mover_hits + 4'd1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_TURN_P1;
      turn      <= 1'b0;
      p1_hits   <= '0;
      p2_hits   <= '0;
      time_left <= TURN_LOAD;
      err_cnt   <= '0;
      new_state <= 8'h00;
      write_en  <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nxt;
      turn      <= turn_nxt;
      p1_hits   <= p1_nxt;
      p2_hits   <= p2_nxt;
      time_left <= time_nxt;
      err_cnt   <= err_nxt;
      new_state <= code_nxt;
      write_en  <= we_nxt;
      game_over <= over_nxt;
    end
  end

  // NOTE: every combinational output is given a default first so no path
  // through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    if (restart) begin
      state_nxt = ST_TURN_P1;
    end else begin
      case (state)
        ST_TURN_P1, ST_TURN_P2: begin
          if (move_valid) begin
            if (!move_ok)
              state_nxt = ST_ERROR;
            else if (hit && mover_inc == WIN_COUNT)
              state_nxt = ST_GAME_OVER;
            else
              state_nxt = turn ? ST_TURN_P1 : ST_TURN_P2;
          end else if (tick && time_left == 6'd1) begin
            state_nxt = turn ? ST_TURN_P1 : ST_TURN_P2;
          end
        end
        ST_ERROR: begin
          if (tick && err_cnt == ERR_LAST)
            state_nxt = turn ? ST_TURN_P2 : ST_TURN_P1;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    turn_nxt = turn;
    p1_nxt   = p1_hits;
    p2_nxt   = p2_hits;
    time_nxt = time_left;
    err_nxt  = err_cnt;
    if (restart) begin
      turn_nxt = 1'b0;
      p1_nxt   = '0;
      p2_nxt   = '0;
      time_nxt = TURN_LOAD;
      err_nxt  = '0;
    end else begin
      case (state)
        ST_TURN_P1, ST_TURN_P2: begin
          // A move in the same cycle as a tick takes precedence; the tick is lost.
          if (move_valid) begin
            if (move_ok) begin
              if (hit) begin
                if (turn) p2_nxt = mover_inc;
                else      p1_nxt = mover_inc;
              end
              if (state_nxt != ST_GAME_OVER) begin
                turn_nxt = ~turn;
                time_nxt = TURN_LOAD;
              end
            end else begin
              err_nxt = '0;
            end
          end else if (tick) begin
            if (time_left == 6'd1) begin
              turn_nxt = ~turn;
              time_nxt = TURN_LOAD;
            end else begin
              time_nxt = time_left - 6'd1;
            end
          end
        end
        ST_ERROR: begin
          if (tick) begin
            if (err_cnt == ERR_LAST) begin
              time_nxt = TURN_LOAD;
              err_nxt  = '0;
            end else begin
              err_nxt = err_cnt + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end

    case (state_nxt)
      ST_TURN_P1:   code_nxt = 8'h00;
      ST_TURN_P2:   code_nxt = 8'h01;
      ST_ERROR:     code_nxt = {7'b1000000, turn_nxt};
      default:      code_nxt = {7'b0100000, turn_nxt};
    endcase
    // Restart always rewrites 0x00 even if the register already holds it.
    we_nxt   = restart || (code_nxt != new_state);
    over_nxt = (state_nxt == ST_GAME_OVER);
  end

endmodule

// File: tb/tb_game_turn_controller.sv
// Self-checking bench for game_turn_controller: directed scenarios followed by
// random traffic, all compared each cycle against a rule-level reference model.
module tb_game_turn_controller;

  localparam int HTW = 5;
  localparam int TT  = 30;
  localparam int ET  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick, restart, move_valid, move_ok, hit;
  logic       write_en, turn, game_over;
  logic [7:0] new_state;
  logic [3:0] p1_hits, p2_hits;
  logic [5:0] time_left;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: phase 0 = playing, 1 = error penalty, 2 = game over.
  int         m_phase, m_player, m_time, m_err_ticks;
  int         m_hits[2];
  logic [7:0] m_code;
  logic       m_we;

  game_turn_controller #(
    .HITS_TO_WIN(HTW), .TURN_TICKS(TT), .ERR_TICKS(ET)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .restart(restart),
    .move_valid(move_valid), .move_ok(move_ok), .hit(hit),
    .write_en(write_en), .new_state(new_state), .turn(turn),
    .p1_hits(p1_hits), .p2_hits(p2_hits), .time_left(time_left),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_phase = 0; m_player = 0; m_time = TT; m_err_ticks = 0;
    m_hits[0] = 0; m_hits[1] = 0;
    m_code = 8'h00; m_we = 1'b0;
  endtask

  task automatic model_step(input logic t, input logic r, input logic mv,
                            input logic ok, input logic h);
    logic [7:0] code;
    bit         pass_turn = 0;
    if (r) begin
      m_phase = 0; m_player = 0; m_time = TT; m_err_ticks = 0;
      m_hits[0] = 0; m_hits[1] = 0;
    end else if (m_phase == 0) begin
      if (mv) begin
        if (!ok) begin
          m_phase = 1; m_err_ticks = 0;
        end else begin
          if (h) m_hits[m_player] = (m_hits[m_player] >= 15) ? 15 : m_hits[m_player] + 1;
          if (h && m_hits[m_player] == HTW) m_phase = 2;
          else pass_turn = 1;
        end
      end else if (t) begin
        if (m_time == 1) pass_turn = 1;
        else m_time = m_time - 1;
      end
    end else if (m_phase == 1) begin
      if (t) begin
        m_err_ticks++;
        if (m_err_ticks == ET) begin
          m_phase = 0; m_time = TT;
        end
      end
    end
    if (pass_turn) begin
      m_player = 1 - m_player;
      m_time = TT;
    end
    code = 8'(m_player);
    if (m_phase == 1) code = code | 8'h80;
    if (m_phase == 2) code = code | 8'h40;
    m_we = r || (code != m_code);
    m_code = code;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("write_en",  {7'b0, write_en},  {7'b0, m_we});
    check("new_state", new_state,         m_code);
    check("turn",      {7'b0, turn},      8'(m_player));
    check("p1_hits",   {4'b0, p1_hits},   8'(m_hits[0]));
    check("p2_hits",   {4'b0, p2_hits},   8'(m_hits[1]));
    check("time_left", {2'b0, time_left}, 8'(m_time));
    check("game_over", {7'b0, game_over}, {7'b0, m_phase == 2});
  endtask

  // Inputs change at the falling edge; outputs are checked at the next falling edge.
  task automatic cycle(input logic t, input logic r, input logic mv,
                       input logic ok, input logic h);
    tick = t; restart = r; move_valid = mv; move_ok = ok; hit = h;
    @(posedge clk);
    model_step(t, r, mv, ok, h);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst = 1'b0; tick = 0; restart = 0; move_valid = 0; move_ok = 0; hit = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_all();
    rst = 1'b1;

    // Timer counts down with no write.
    repeat (3) cycle(1, 0, 0, 0, 0);
    check("tl_after_3_ticks", {2'b0, time_left}, 8'd27);
    // P1 legal miss passes the turn.
    cycle(0, 0, 1, 1, 0);
    check("miss_code", new_state, 8'h01);
    // P2 legal miss, then P1 illegal move and the error penalty.
    cycle(0, 0, 1, 1, 0);
    cycle(0, 0, 1, 0, 0);
    check("err_code", new_state, 8'h80);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 1, 1);
    cycle(1, 0, 0, 0, 0);
    check("err_return", new_state, 8'h00);
    // Full timeout, then tick and legal move together at time_left = 1.
    repeat (TT) cycle(1, 0, 0, 0, 0);
    check("timeout_code", new_state, 8'h01);
    repeat (TT - 1) cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, 1, 0);
    check("tick_move_tl", {2'b0, time_left}, 8'(TT));
    // Alternate hits until P1 wins.
    repeat (HTW - 1) begin
      cycle(0, 0, 1, 1, 1);
      cycle(0, 0, 1, 1, 1);
    end
    cycle(0, 0, 1, 1, 1);
    check("win_code", new_state, 8'h40);
    repeat (4) cycle(1, 0, 1, 1, 1);
    cycle(0, 0, 1, 0, 0);
    check("frozen_p2", {4'b0, p2_hits}, 8'd4);
    // Restart, held for several cycles.
    repeat (3) cycle(0, 1, 1, 1, 1);
    cycle(0, 0, 0, 0, 0);
    // Async reset while an error write is in flight.
    cycle(0, 0, 1, 0, 0);
    tick = 0; restart = 0; move_valid = 0; move_ok = 0; hit = 0;
    #2 rst = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b1;
    cycle(0, 0, 0, 0, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 3) == 0, ($urandom % 100) == 0, ($urandom % 4) == 0,
            ($urandom % 4) != 0, ($urandom % 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/game_turn_controller.md
Name: game_turn_controller

Overview:
- Two-player turn/scoring FSM for the game datapath.
- Consumes validated move events from the move checker and a 1 Hz tick from the clock divider.
- Tracks turn, per-player hit counts and turn timeout.
- Produces the 8-bit status code plus a one-cycle write strobe that feed the status register (new_state/write_en) directly downstream.

Parameters:
- HITS_TO_WIN, 5, hits needed to win; legal 1..15.
- TURN_TICKS, 30, ticks allowed per turn before forced pass; legal 2..63.
- ERR_TICKS, 2, ticks the error status is held; legal 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle enable, 1 Hz
- restart  in  1  synchronous new-game request, level sampled each cycle
- move_valid  in  1  one-cycle pulse: current player submitted a move
- move_ok  in  1  move is legal; qualified by move_valid
- hit  in  1  move scored a hit; qualified by move_valid && move_ok
- write_en  out  1  one-cycle strobe to the status register
- new_state  out  8  status code to the status register
- turn  out  1  0 = player 1, 1 = player 2
- p1_hits  out  4  player 1 hit count
- p2_hits  out  4  player 2 hit count
- time_left  out  6  remaining ticks in the current turn
- game_over  out  1  high in GAME_OVER

Behaviour:
- Status encoding:
  - bit0 = player concerned; bit6 = game over; bit7 = error.
  - PLAY_P1 = 0x00, PLAY_P2 = 0x01, ERR_P1 = 0x80, ERR_P2 = 0x81, WIN_P1 = 0x40, WIN_P2 = 0x41.
- FSM states: TURN_P1, TURN_P2, ERROR, GAME_OVER. ERROR remembers the player who erred.
- Reset values: state = TURN_P1, new_state = 0x00, write_en = 0, turn = 0, hits = 0, time_left = TURN_TICKS, game_over = 0. No write is issued after reset; the downstream register already resets to 0x00.
- All outputs are registered.
  - An event sampled at edge N updates state and outputs at edge N.
  - write_en is high for exactly the cycle after edge N, and new_state holds the new code.
  - The status register captures at edge N+1.
- write_en pulses only when the status code changes, except on restart, which always pulses with 0x00.
- TURN_Px transitions:
  - move_valid && !move_ok → ERROR; code ERR_Px; timer frozen; hit ignored.
  - move_valid && move_ok && hit: increment mover's counter.
    - If the new count == HITS_TO_WIN → GAME_OVER with WIN_Px.
    - Otherwise pass turn.
  - move_valid && move_ok && !hit → pass turn.
  - tick with time_left == 1 and no move_valid → timeout: pass turn.
  - tick otherwise → time_left decrements.
  - Pass turn means: switch player, reload time_left = TURN_TICKS, emit PLAY of the new player.
  - move_valid and tick in the same cycle: the move wins; the tick is discarded; the timer reloads if the turn passes.
- ERROR:
  - Counts ERR_TICKS ticks.
  - On the last tick, returns to the same player's turn with time_left reloaded and PLAY_Px written.
  - move_valid is ignored in ERROR.
- GAME_OVER:
  - Absorbing state; all moves and ticks are ignored.
  - game_over = 1; the hit counters hold their values.
- Hit counters saturate at 15. This is unreachable with legal HITS_TO_WIN but must not wrap.
- restart has priority over every other input in every state.
  - Next state is TURN_P1; hits cleared; timer reloaded; game_over = 0; write_en pulse with 0x00.
  - Restart held high for several cycles produces a write each cycle.
- Asynchronous reset mid-game clears everything immediately to the reset values; the in-flight write_en is dropped.

Test Plan:
- Reset; drive 3 ticks → time_left 30→27; no write_en; new_state = 0x00.
- P1 legal miss (move_valid = 1, move_ok = 1, hit = 0) → next cycle write_en = 1, new_state = 0x01, turn = 1, time_left = 30.
- P1 illegal move → write 0x80; 1 tick → time_left unchanged, no write; 2nd tick → write 0x00, turn = 0, time_left = 30.
- 30 ticks with no move in TURN_P1 → on the 30th tick write 0x01. Same-cycle tick + legal move at time_left = 1 → single write 0x01, time_left = 30.
- Alternate legal hits until p1_hits = 5 → write 0x40, game_over = 1; further moves/ticks give no write and the counters frozen (p1_hits = 5, p2_hits = 4).
- restart in GAME_OVER → write 0x00, hits 0/0, turn = 0. Async reset asserted mid-ERROR → all outputs at reset values within the same cycle, no write_en.
